// File: rtl/pc_sequencer_if.sv
// Control and decode bundle between the host/decoder side and the PC sequencer.
interface pc_sequencer_if #(
  parameter int PC_WIDTH  = 3,
  parameter int OFF_WIDTH = 4,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 step;
  logic                 halt_req;
  logic                 stall;
  logic                 sig_branch;
  logic                 zero_flag;
  logic                 sig_jump;
  logic [OFF_WIDTH-1:0] branch_off;
  logic [PC_WIDTH-1:0]  jump_target;
  logic [PC_WIDTH-1:0]  pc;
  logic                 running;
  logic                 halted;
  logic                 redirect;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    output start, step, halt_req, stall, sig_branch, zero_flag, sig_jump,
           branch_off, jump_target,
    input  pc, running, halted, redirect, retired
  );

  modport slave (
    input  start, step, halt_req, stall, sig_branch, zero_flag, sig_jump,
           branch_off, jump_target,
    output pc, running, halted, redirect, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer with run, single-step and halt control,
// zero-bubble jump/branch resolution and a saturating retired-instruction count.
module pc_sequencer #(
  parameter int PC_WIDTH  = 3,
  parameter int OFF_WIDTH = 4,
  parameter int LAST_ADDR = 7,
  parameter int CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  // Offset is sign-extended to whichever of pc/offset is wider, then the low
  // PC_WIDTH bits are used: arithmetic wraps modulo 2^PC_WIDTH.
  localparam int SW = (PC_WIDTH > OFF_WIDTH) ? PC_WIDTH : OFF_WIDTH;
  localparam logic [PC_WIDTH-1:0] LAST = PC_WIDTH'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t               state, state_nx;
  logic [PC_WIDTH-1:0]  pc_q, pc_nx;
  logic                 redirect_q, redirect_nx;
  logic [CNT_WIDTH-1:0] retired_q, retired_nx;

  logic                 adv;
  logic                 taken;
  logic [SW-1:0]        off_ext;
  logic [PC_WIDTH-1:0]  seq_pc;
  logic [PC_WIDTH-1:0]  br_pc;

  assign off_ext = SW'($signed(bus.branch_off));
  assign seq_pc  = pc_q + PC_WIDTH'(1);
  assign br_pc   = seq_pc + off_ext[PC_WIDTH-1:0];
  assign taken   = bus.sig_branch & bus.zero_flag;

  // halt_req and stall both suppress the advance; start in IDLE wins over step.
  assign adv = ~bus.stall & ~bus.halt_req &
               ((state == RUN) | ((state == IDLE) & bus.step & ~bus.start));

  // Next-state, next-PC and retire bookkeeping.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc_q;
    redirect_nx = redirect_q;
    retired_nx  = retired_q;

    case (state)
      IDLE: begin
        if (bus.halt_req)                  state_nx = HALT;
        else if (!bus.stall && bus.start)  state_nx = RUN;
      end
      RUN:     if (bus.halt_req) state_nx = HALT;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase

    if (adv) begin
      retired_nx  = (&retired_q) ? retired_q : retired_q + CNT_WIDTH'(1);
      redirect_nx = bus.sig_jump | taken;
      if (bus.sig_jump)    pc_nx = bus.jump_target;
      else if (taken)      pc_nx = br_pc;
      else if (pc_q == LAST) state_nx = HALT;  // retire the last one, pc stays put
      else                 pc_nx = seq_pc;
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc_q       <= '0;
      redirect_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state      <= state_nx;
      pc_q       <= pc_nx;
      redirect_q <= redirect_nx;
      retired_q  <= retired_nx;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.running  = (state == RUN);
  assign bus.halted   = (state == HALT);
  assign bus.redirect = redirect_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the sequencer rules.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  // model state
  int m_pc, m_ret;
  bit m_redir, m_run, m_halt;

  pc_sequencer_if #(.PC_WIDTH(3), .OFF_WIDTH(4), .CNT_WIDTH(16)) bus ();

  pc_sequencer #(.PC_WIDTH(3), .OFF_WIDTH(4), .LAST_ADDR(7), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rst = 0; bus.start = 0; bus.step = 0; bus.halt_req = 0; bus.stall = 0;
    bus.sig_branch = 0; bus.zero_flag = 0; bus.sig_jump = 0;
    bus.branch_off = '0; bus.jump_target = '0;
  endtask

  // One clock of the reference behaviour, from the current inputs.
  task automatic model_step();
    int off;
    bit adv;
    if (rst) begin
      m_pc = 0; m_ret = 0; m_redir = 0; m_run = 0; m_halt = 0;
      return;
    end
    adv = !bus.stall && !bus.halt_req &&
          (m_run || (!m_run && !m_halt && bus.step && !bus.start));
    if (adv) begin
      m_ret   = (m_ret == 65535) ? m_ret : m_ret + 1;
      m_redir = bus.sig_jump || (bus.sig_branch && bus.zero_flag);
      off = int'(bus.branch_off);
      if (off > 7) off -= 16;
      if (bus.sig_jump)                         m_pc = int'(bus.jump_target);
      else if (bus.sig_branch && bus.zero_flag) m_pc = ((m_pc + 1 + off) % 8 + 8) % 8;
      else if (m_pc == 7) begin m_halt = 1; m_run = 0; end
      else                                      m_pc = (m_pc + 1) % 8;
    end
    if (!m_halt) begin
      if (bus.halt_req) begin m_halt = 1; m_run = 0; end
      else if (!m_run && !bus.stall && bus.start) m_run = 1;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus.pc !== 3'd0)       begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", bus.pc); end
    n_chk++; if (bus.running !== 1'b0)  begin n_fail++; $display("FAIL reset_running: got %0d expected 0", bus.running); end
    n_chk++; if (bus.halted !== 1'b0)   begin n_fail++; $display("FAIL reset_halted: got %0d expected 0", bus.halted); end
    n_chk++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %0d expected 0", bus.redirect); end
    n_chk++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", bus.retired); end
  endtask

  task automatic test_sequential();
    do_reset();
    bus.start = 1; cyc(); bus.start = 0;
    n_chk++; if (bus.running !== 1'b1 || bus.pc !== 3'd0) begin n_fail++; $display("FAIL seq_start: got run=%0d pc=%0d expected run=1 pc=0", bus.running, bus.pc); end
    for (int k = 1; k <= 7; k++) begin
      cyc();
      n_chk++; if (int'(bus.pc) != k) begin n_fail++; $display("FAIL seq_pc: got %0d expected %0d", bus.pc, k); end
    end
    cyc();
    n_chk++; if (bus.halted !== 1'b1 || bus.running !== 1'b0) begin n_fail++; $display("FAIL seq_halt: got halted=%0d running=%0d expected 1 0", bus.halted, bus.running); end
    n_chk++; if (bus.pc !== 3'd7 || bus.retired !== 16'd8) begin n_fail++; $display("FAIL seq_end: got pc=%0d retired=%0d expected pc=7 retired=8", bus.pc, bus.retired); end
  endtask

  task automatic test_branch();
    do_reset();
    bus.start = 1; cyc(); bus.start = 0;
    cyc(); cyc();
    bus.sig_branch = 1; bus.zero_flag = 1; bus.branch_off = 4'b1110;
    cyc();
    n_chk++; if (bus.pc !== 3'd1 || bus.redirect !== 1'b1) begin n_fail++; $display("FAIL br_taken: got pc=%0d redirect=%0d expected pc=1 redirect=1", bus.pc, bus.redirect); end
    bus.sig_branch = 0; bus.zero_flag = 0;
    cyc();
    n_chk++; if (bus.pc !== 3'd2 || bus.redirect !== 1'b0) begin n_fail++; $display("FAIL br_fall: got pc=%0d redirect=%0d expected pc=2 redirect=0", bus.pc, bus.redirect); end
    bus.sig_branch = 1; bus.zero_flag = 0;
    cyc();
    n_chk++; if (bus.pc !== 3'd3 || bus.redirect !== 1'b0) begin n_fail++; $display("FAIL br_not_taken: got pc=%0d redirect=%0d expected pc=3 redirect=0", bus.pc, bus.redirect); end
  endtask

  task automatic test_jump_wrap();
    do_reset();
    bus.start = 1; cyc(); bus.start = 0;
    repeat (6) cyc();
    bus.sig_jump = 1; bus.jump_target = 3'd0; bus.sig_branch = 1; bus.zero_flag = 1; bus.branch_off = 4'd3;
    cyc();
    n_chk++; if (bus.pc !== 3'd0 || bus.redirect !== 1'b1) begin n_fail++; $display("FAIL jump_prio: got pc=%0d redirect=%0d expected pc=0 redirect=1", bus.pc, bus.redirect); end
    clear_inputs();
    repeat (7) cyc();
    n_chk++; if (bus.pc !== 3'd7) begin n_fail++; $display("FAIL wrap_setup: got pc=%0d expected 7", bus.pc); end
    bus.sig_branch = 1; bus.zero_flag = 1; bus.branch_off = 4'd1;
    cyc();
    n_chk++; if (bus.pc !== 3'd1 || bus.halted !== 1'b0 || bus.running !== 1'b1) begin n_fail++; $display("FAIL wrap: got pc=%0d halted=%0d running=%0d expected pc=1 halted=0 running=1", bus.pc, bus.halted, bus.running); end
  endtask

  task automatic test_stall_halt();
    do_reset();
    bus.start = 1; cyc(); bus.start = 0;
    repeat (3) cyc();
    bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_chk++; if (bus.pc !== 3'd3 || bus.retired !== 16'd3) begin n_fail++; $display("FAIL stall_hold: got pc=%0d retired=%0d expected pc=3 retired=3", bus.pc, bus.retired); end
    end
    bus.halt_req = 1;
    cyc();
    clear_inputs();
    n_chk++; if (bus.halted !== 1'b1 || bus.pc !== 3'd3 || bus.running !== 1'b0) begin n_fail++; $display("FAIL stall_halt: got halted=%0d pc=%0d running=%0d expected 1 3 0", bus.halted, bus.pc, bus.running); end
    bus.start = 1; bus.step = 1;
    cyc(); cyc();
    clear_inputs();
    n_chk++; if (bus.halted !== 1'b1 || bus.running !== 1'b0 || bus.pc !== 3'd3 || bus.retired !== 16'd3) begin n_fail++; $display("FAIL halt_absorb: got halted=%0d running=%0d pc=%0d retired=%0d expected 1 0 3 3", bus.halted, bus.running, bus.pc, bus.retired); end
  endtask

  task automatic test_step();
    do_reset();
    bus.step = 1; cyc(); bus.step = 0;
    n_chk++; if (bus.pc !== 3'd1 || bus.retired !== 16'd1 || bus.running !== 1'b0) begin n_fail++; $display("FAIL step1: got pc=%0d retired=%0d running=%0d expected 1 1 0", bus.pc, bus.retired, bus.running); end
    repeat (2) begin
      cyc();
      n_chk++; if (bus.pc !== 3'd1 || bus.running !== 1'b0) begin n_fail++; $display("FAIL step_idle: got pc=%0d running=%0d expected 1 0", bus.pc, bus.running); end
    end
    bus.step = 1; cyc(); bus.step = 0;
    n_chk++; if (bus.pc !== 3'd2 || bus.retired !== 16'd2 || bus.running !== 1'b0) begin n_fail++; $display("FAIL step2: got pc=%0d retired=%0d running=%0d expected 2 2 0", bus.pc, bus.retired, bus.running); end
    bus.start = 1; bus.step = 1; cyc(); clear_inputs();
    n_chk++; if (bus.running !== 1'b1 || bus.pc !== 3'd2 || bus.retired !== 16'd2) begin n_fail++; $display("FAIL start_beats_step: got running=%0d pc=%0d retired=%0d expected 1 2 2", bus.running, bus.pc, bus.retired); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.start = 1; cyc(); bus.start = 0;
    repeat (5) cyc();
    n_chk++; if (bus.pc !== 3'd5 || bus.retired !== 16'd5) begin n_fail++; $display("FAIL mid_setup: got pc=%0d retired=%0d expected 5 5", bus.pc, bus.retired); end
    rst = 1; cyc(); rst = 0;
    n_chk++; if (bus.pc !== 3'd0 || bus.retired !== 16'd0 || bus.running !== 1'b0 || bus.halted !== 1'b0 || bus.redirect !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset: got pc=%0d retired=%0d running=%0d halted=%0d redirect=%0d expected all 0", bus.pc, bus.retired, bus.running, bus.halted, bus.redirect); end
    cyc();
    n_chk++; if (bus.pc !== 3'd0 || bus.running !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got pc=%0d running=%0d expected 0 0", bus.pc, bus.running); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) < 3);
      bus.start      = ($urandom_range(0, 99) < 20);
      bus.step       = ($urandom_range(0, 99) < 40);
      bus.halt_req   = ($urandom_range(0, 99) < 3);
      bus.stall      = ($urandom_range(0, 99) < 20);
      bus.sig_branch = ($urandom_range(0, 99) < 25);
      bus.zero_flag  = $urandom_range(0, 1);
      bus.sig_jump   = ($urandom_range(0, 99) < 10);
      bus.branch_off = 4'($urandom_range(0, 15));
      bus.jump_target = 3'($urandom_range(0, 7));
      cyc();
      n_chk++;
      if (int'(bus.pc) != m_pc || bus.retired !== 16'(m_ret) || bus.redirect !== m_redir ||
          bus.running !== m_run || bus.halted !== m_halt) begin
        n_fail++;
        $display("FAIL rand[%0d]: got pc=%0d ret=%0d redir=%0d run=%0d halt=%0d expected pc=%0d ret=%0d redir=%0d run=%0d halt=%0d",
                 i, bus.pc, bus.retired, bus.redirect, bus.running, bus.halted, m_pc, m_ret, m_redir, m_run, m_halt);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_wrap();
    test_stall_halt();
    test_step();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
